// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception entry/return sequencer owning EPC and the handler PC source (optional macro: EXC_DIV0_EN)
module exception_sequencer #(
    parameter logic [7:0] VEC_OPC = 8'd253,
    parameter logic [7:0] VEC_OVF = 8'd254,
    parameter logic [7:0] VEC_DIV = 8'd255,
    parameter int         MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        exc_opc,
    input  logic        exc_ovf,
    input  logic        exc_div,
    input  logic        eret,
    input  logic [7:0]  mem_byte,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] epc_q,
    output logic [1:0]  cause_q,
    output logic [31:0] handler_addr,
    output logic [1:0]  pc_source,
    output logic        exc_pc_write,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_RET  = 3'd4
    } state_t;

    // WAIT ends on the cycle the memory byte is valid
    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  vec_q;
    logic [7:0]  byte_q;
    logic        div_req;
    logic        exc_any;
    logic        wait_done;

`ifdef EXC_DIV0_EN
    assign div_req = exc_div;
`else
    // Divide-by-zero source is compiled out; the port is kept for a uniform top level
    logic unused_div;
    assign unused_div = exc_div;
    assign div_req    = 1'b0;
`endif

    assign exc_any   = exc_opc | exc_ovf | div_req;
    assign wait_done = (cnt_q == LAST_CNT);

    // State and latency counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, exceptions beat eret
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (exc_any) begin
                    state_d = S_READ;
                end else if (eret) begin
                    state_d = S_RET;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = 3'd0;
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LOAD:  state_d = S_IDLE;
            S_RET:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // EPC, cause and vector capture on exception entry; handler byte at end of WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
            vec_q   <= 8'd0;
            byte_q  <= 8'd0;
        end else begin
            if (state_q == S_IDLE && exc_any) begin
                epc_q <= pc_in - 32'd4;
                if (exc_opc) begin
                    cause_q <= 2'b01;
                    vec_q   <= VEC_OPC;
                end else if (exc_ovf) begin
                    cause_q <= 2'b10;
                    vec_q   <= VEC_OVF;
                end else begin
                    cause_q <= 2'b11;
                    vec_q   <= VEC_DIV;
                end
            end
            if (state_q == S_WAIT && wait_done) begin
                byte_q <= mem_byte;
            end
        end
    end

    // Control outputs decoded purely from the state register
    always_comb begin
        mem_rd       = 1'b0;
        exc_pc_write = 1'b0;
        pc_source    = 2'b00;
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_READ, S_WAIT: mem_rd = 1'b1;
            S_LOAD: begin
                exc_pc_write = 1'b1;
                pc_source    = 2'b11;
            end
            S_RET: begin
                exc_pc_write = 1'b1;
                pc_source    = 2'b01;
            end
            default: ;
        endcase
    end

    assign mem_addr     = {24'b0, vec_q};
    assign handler_addr = {24'b0, byte_q};

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - self-checking bench for exception_sequencer at MEM_LAT 1 and 3
module tb_exception_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        exc_opc, exc_ovf, exc_div, eret;
    logic [7:0]  mem_byte;

    logic        a_mem_rd, b_mem_rd;
    logic [31:0] a_mem_addr, b_mem_addr;
    logic [31:0] a_epc, b_epc;
    logic [1:0]  a_cause, b_cause;
    logic [31:0] a_handler, b_handler;
    logic [1:0]  a_src, b_src;
    logic        a_wr, b_wr;
    logic        a_busy, b_busy;

    int n_vec = 0;
    int n_mis = 0;
    bit cmp_en = 0;
    bit vary = 0;

`ifdef EXC_DIV0_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    exception_sequencer #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in),
        .exc_opc(exc_opc), .exc_ovf(exc_ovf), .exc_div(exc_div), .eret(eret),
        .mem_byte(mem_byte), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr),
        .epc_q(a_epc), .cause_q(a_cause), .handler_addr(a_handler),
        .pc_source(a_src), .exc_pc_write(a_wr), .busy(a_busy)
    );

    exception_sequencer #(.MEM_LAT(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in),
        .exc_opc(exc_opc), .exc_ovf(exc_ovf), .exc_div(exc_div), .eret(eret),
        .mem_byte(mem_byte), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
        .epc_q(b_epc), .cause_q(b_cause), .handler_addr(b_handler),
        .pc_source(b_src), .exc_pc_write(b_wr), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence model: each instance is either idle or at some cycle offset into a
    // sequence. Exception: offset 0 = read, 1..lat = waiting, lat+1 = PC load. Return: offset 0 only.
    int          lat [2] = '{1, 3};
    logic        mb  [2];
    logic        mk  [2];
    int          mp  [2];
    logic [31:0] me  [2];
    logic [1:0]  mc  [2];
    logic [7:0]  mv  [2];
    logic [7:0]  mh  [2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                mb[i] <= 1'b0; mk[i] <= 1'b0; mp[i] <= 0;
                me[i] <= 32'd0; mc[i] <= 2'd0; mv[i] <= 8'd0; mh[i] <= 8'd0;
            end else if (!mb[i]) begin
                if (exc_opc || exc_ovf || (DIV_EN && exc_div)) begin
                    mb[i] <= 1'b1; mk[i] <= 1'b0; mp[i] <= 0;
                    me[i] <= pc_in - 32'd4;
                    mc[i] <= exc_opc ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
                    mv[i] <= exc_opc ? 8'd253 : (exc_ovf ? 8'd254 : 8'd255);
                end else if (eret) begin
                    mb[i] <= 1'b1; mk[i] <= 1'b1; mp[i] <= 0;
                end
            end else if (mk[i]) begin
                mb[i] <= 1'b0;
            end else begin
                if (mp[i] == lat[i]) mh[i] <= mem_byte;
                if (mp[i] == lat[i] + 1) mb[i] <= 1'b0;
                else mp[i] <= mp[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic bz, input logic rd, input logic [31:0] addr,
                            input logic [31:0] epc, input logic [1:0] cause, input logic [31:0] ha,
                            input logic [1:0] src, input logic wr);
        string p;
        logic e_rd, e_wr;
        logic [1:0] e_src;
        p     = (i == 0) ? "A" : "B";
        e_rd  = mb[i] && !mk[i] && (mp[i] <= lat[i]);
        e_wr  = mb[i] && (mk[i] || (mp[i] == lat[i] + 1));
        e_src = e_wr ? (mk[i] ? 2'b01 : 2'b11) : 2'b00;
        chk({p, " busy"},         {31'b0, bz},   {31'b0, mb[i]});
        chk({p, " mem_rd"},       {31'b0, rd},   {31'b0, e_rd});
        chk({p, " mem_addr"},     addr,          {24'b0, mv[i]});
        chk({p, " epc_q"},        epc,           me[i]);
        chk({p, " cause_q"},      {30'b0, cause}, {30'b0, mc[i]});
        chk({p, " handler_addr"}, ha,            {24'b0, mh[i]});
        chk({p, " pc_source"},    {30'b0, src},  {30'b0, e_src});
        chk({p, " exc_pc_write"}, {31'b0, wr},   {31'b0, e_wr});
    endtask

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                cmp_inst(0, a_busy, a_mem_rd, a_mem_addr, a_epc, a_cause, a_handler, a_src, a_wr);
                cmp_inst(1, b_busy, b_mem_rd, b_mem_addr, b_epc, b_cause, b_handler, b_src, b_wr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        if (vary) mem_byte = mem_byte + 8'h13;
    endtask

    task automatic pulse(input logic o, input logic v, input logic d, input logic e);
        exc_opc = o; exc_ovf = v; exc_div = d; eret = e;
        cyc();
        exc_opc = 1'b0; exc_ovf = 1'b0; exc_div = 1'b0; eret = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " A busy"},     {31'b0, a_busy},   32'd0);
        chk({tag, " A mem_rd"},   {31'b0, a_mem_rd}, 32'd0);
        chk({tag, " A mem_addr"}, a_mem_addr,        32'd0);
        chk({tag, " A epc"},      a_epc,             32'd0);
        chk({tag, " A cause"},    {30'b0, a_cause},  32'd0);
        chk({tag, " A handler"},  a_handler,         32'd0);
        chk({tag, " A src"},      {30'b0, a_src},    32'd0);
        chk({tag, " A wr"},       {31'b0, a_wr},     32'd0);
        chk({tag, " B busy"},     {31'b0, b_busy},   32'd0);
        chk({tag, " B mem_rd"},   {31'b0, b_mem_rd}, 32'd0);
        chk({tag, " B epc"},      b_epc,             32'd0);
        chk({tag, " B wr"},       {31'b0, b_wr},     32'd0);
    endtask

    int busy_cnt, loads, wr_cnt, ld_at, wr_seen;
    logic [31:0] ha;

    initial begin
        reset_n = 1'b0; pc_in = 32'd0; mem_byte = 8'd0;
        exc_opc = 1'b0; exc_ovf = 1'b0; exc_div = 1'b0; eret = 1'b0;
        repeat (2) cyc();
        cmp_en = 1'b1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // Overflow entry at MEM_LAT=1
        pc_in = 32'h0000_0104; mem_byte = 8'h40;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovf epc", a_epc, 32'h0000_0100);
        chk("ovf cause", {30'b0, a_cause}, 32'd2);
        chk("ovf mem_addr", a_mem_addr, 32'h0000_00FE);
        busy_cnt = a_busy ? 1 : 0; loads = 0; ha = 32'd0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (a_busy) busy_cnt++;
            if (a_wr && a_src == 2'b11) begin loads++; ha = a_handler; end
        end
        chk("ovf busy cycles", busy_cnt, 32'd3);
        chk("ovf load cycles", loads, 32'd1);
        chk("ovf handler", ha, 32'h0000_0040);

        // Return from the overflow handler
        pulse(1'b0, 0, 1'b0, 1'b1);
        wr_cnt = (a_wr && a_src == 2'b01) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (a_wr) wr_cnt++;
        end
        chk("eret pc writes", wr_cnt, 32'd1);
        chk("eret epc kept", a_epc, 32'h0000_0100);

        // Simultaneous opc+ovf: opc wins; handler byte changes every cycle
        vary = 1'b1;
        pc_in = 32'h0000_0200;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("prio cause", {30'b0, a_cause}, 32'd1);
        chk("prio mem_addr", a_mem_addr, 32'h0000_00FD);
        chk("prio epc", a_epc, 32'h0000_01FC);
        repeat (6) cyc();
        vary = 1'b0;

        // EPC wrap at pc_in = 0; eret in the same cycle is dropped
        pc_in = 32'h0;
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrap epc", a_epc, 32'hFFFF_FFFC);
        chk("wrap not ret", {31'b0, a_mem_rd}, 32'd1);
        repeat (6) cyc();

        // Divide-by-zero, with requests during WAIT of the MEM_LAT=3 instance
        pc_in = 32'h0000_0040; mem_byte = 8'h77;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef EXC_DIV0_EN
        cyc();
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("div cause", {30'b0, b_cause}, 32'd3);
        chk("div mem_addr", b_mem_addr, 32'h0000_00FF);
        ld_at = 0;
        for (int k = 3; k < 9; k++) begin
            cyc();
            if (b_wr && ld_at == 0) ld_at = k;
        end
        chk("div load offset", ld_at, 32'd4);
        chk("div handler", b_handler, 32'h0000_0077);
        chk("div cause kept", {30'b0, b_cause}, 32'd3);
        chk("div A idle", {31'b0, a_busy}, 32'd0);
`else
        chk("nodiv A busy", {31'b0, a_busy}, 32'd0);
        chk("nodiv B busy", {31'b0, b_busy}, 32'd0);
        chk("nodiv A mem_rd", {31'b0, a_mem_rd}, 32'd0);
        chk("nodiv B mem_rd", {31'b0, b_mem_rd}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("nodiv B busy later", {31'b0, b_busy}, 32'd0);
        end
`endif
        repeat (6) cyc();

        // Reset asserted while waiting on memory
        pc_in = 32'h0000_1234;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("pre-reset B mem_rd", {31'b0, b_mem_rd}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        cyc();
        reset_n = 1'b1;
        wr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (a_wr || b_wr) wr_seen++;
        end
        chk("post-reset pc writes", wr_seen, 32'd0);

        // eret with EPC never written returns to 0
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fresh eret wr", {31'b0, a_wr}, 32'd1);
        chk("fresh eret src", {30'b0, a_src}, 32'd1);
        chk("fresh eret epc", a_epc, 32'd0);
        repeat (3) cyc();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
